es_stream_to_bin: RTL and testbench
===================================

// Module: es_stream_to_bin
// PURPOSE
// - Receiver end of the ES stochastic datapath: takes one serial bitstream from an ES
//   stream-arithmetic stage and converts it back to binary.
// - Converts by counting the 1s over a full deterministic window of 2^WXI accepted bits.
// - Output width matches the binary result port of the ES multiplier cores (WXIP1 bits),
//   so this block drops in as their back-end converter.
// PARAMETERS
// - DATA_WIDTH  5  bits per original binary operand
// - NUM_INPUTS  2  operands combined into the stream; sets the window length
// - WXI         DATA_WIDTH*NUM_INPUTS (localparam); window = 2^WXI accepted bits
// - WXIP1       WXI+1 (localparam); result width, holds 0..2^WXI inclusive
// PORTS
// - clk           in   1      single clock, rising edge
// - rst           in   1      synchronous, active-high reset
// - en            in   1      global enable; low freezes all state (no bit accepted, no FSM move)
// - start         in   1      begin a new conversion window (pulse)
// - stream_in     in   1      stochastic bit
// - stream_valid  in   1      qualifies stream_in; bit is accepted when en & stream_valid in RUN
// - busy          out  1      high in RUN
// - bin_data_out  out  WXIP1  count of accepted 1s in the last completed window
// - done          out  1      high in DONE; bin_data_out is valid and stable
// BEHAVIOUR
// - Reset: state=IDLE, win_cnt=0, ones_cnt=0, bin_data_out=0, done=0, busy=0.
// - FSM states IDLE, RUN, DONE. All transitions require en=1.
//   - IDLE --start--> RUN: clear win_cnt and ones_cnt.
//   - RUN: on each accepted bit, win_cnt++ and ones_cnt += stream_in.
//   - RUN --accepted bit with win_cnt==2^WXI-1--> DONE:
//     bin_data_out <= ones_cnt + stream_in (final bit included).
//   - DONE --start--> RUN: counters clear, done drops the next cycle;
//     bin_data_out holds the old result until the new window completes.
//   - start in RUN is ignored; the window is not restarted.
// - Timing: done rises on the cycle after the 2^WXI-th accepted bit.
//   With stream_valid tied high, start-to-done latency is 2^WXI+1 cycles.
// - Widths
//   - win_cnt is WXI bits; it wraps to 0 exactly on the terminal bit.
//   - ones_cnt is WXIP1 bits and never overflows; an all-ones window gives exactly 2^WXI.
// - Boundaries
//   - stream_valid low: hold all counters, no timeout.
//   - en low mid-RUN: full freeze, resume on the next en.
//   - start and the terminal bit in the same RUN cycle: the terminal bit wins and the
//     FSM enters DONE; start is dropped.
//   - rst mid-window: abandons the window, returns to reset values (result cleared).
//   - start while rst=1: ignored.
// STRUCTURE
// - Shared package es_pkg holds:
//   - typedef enum {ES_IDLE, ES_RUN, ES_DONE} es_conv_state_t
//   - function es_wxi(dw, ni) returning dw*ni
// - Sub-module es_ones_counter (WXIP1-bit clearable, enable-gated accumulator)
//   holds ones_cnt. The FSM and window counter stay in the top module.
// TESTING (defaults: WXI=10, window=1024, WXIP1=11)
// - All-ones: stream_in=1, valid=1 for 1024 cycles after start
//   -> done on cycle 1025, bin_data_out=1024 (11'h400).
// - All-zeros window -> bin_data_out=0, done asserted.
// - Alternating 1/0 starting with 1 -> bin_data_out=512; first-1-per-32 pattern -> 32.
// - Random valid gaps (~50% duty), all-ones data -> result 1024 only after exactly 1024
//   accepted bits; en low for 20 cycles mid-run -> no count change during the freeze.
// - rst at accepted bit 600 -> next cycle state IDLE, bin_data_out=0, done=0;
//   a new start gives a clean full window.
// - Back-to-back: start in DONE (prev result 1024), then all-zeros window
//   -> done low 1 cycle later, bin_data_out stays 1024 until the new done, then 0;
//   start pulsed mid-RUN has no effect.

Source files
------------

// File: rtl/es_pkg.sv
// Shared types and helpers for the ES stochastic-to-binary datapath.
package es_pkg;

    typedef enum logic [1:0] {
        ES_IDLE,
        ES_RUN,
        ES_DONE
    } es_conv_state_t;

    function automatic int es_wxi(input int dw, input int ni);
        return dw * ni;
    endfunction

endpackage

// File: rtl/es_stream_to_bin_if.sv
// Bundle of control, stream and result signals for the stream-to-binary converter.
interface es_stream_to_bin_if #(
    parameter int WXIP1 = 11
);
    import es_pkg::*;

    // Handshake: there is no backpressure. A bit transfers on any rising clk where
    // en & stream_valid are high while busy; start is a single-cycle request and
    // bin_data_out is meaningful whenever done is high.
    logic             en;
    logic             start;
    logic             stream_in;
    logic             stream_valid;
    logic             busy;
    logic [WXIP1-1:0] bin_data_out;
    logic             done;
    es_conv_state_t   dbg_state;

    modport master (
        output en, start, stream_in, stream_valid,
        input  busy, bin_data_out, done, dbg_state
    );

    modport slave (
        input  en, start, stream_in, stream_valid,
        output busy, bin_data_out, done, dbg_state
    );

endinterface

// File: rtl/es_ones_counter.sv
// Clearable, enable-gated accumulator of stream 1s; wide enough for an all-ones window.
module es_ones_counter #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_en_i,
    input  logic         bit_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_en_i) begin
            cnt_d = cnt_q + W'(bit_i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/es_stream_to_bin.sv
// Converts a stochastic bitstream to binary by counting 1s over a 2^WXI-bit window.
module es_stream_to_bin
    import es_pkg::*;
#(
    parameter int DATA_WIDTH = 5,
    parameter int NUM_INPUTS = 2
) (
    input logic               clk,
    input logic               rst,
    es_stream_to_bin_if.slave bus
);

    localparam int WXI   = es_wxi(DATA_WIDTH, NUM_INPUTS);
    localparam int WXIP1 = WXI + 1;

    es_conv_state_t   state_q, state_d;
    logic [WXI-1:0]   win_cnt_q, win_cnt_d;
    logic [WXIP1-1:0] result_q, result_d;
    logic [WXIP1-1:0] ones_cnt;
    logic             accept;
    logic             terminal;
    logic             clr;

    assign accept   = bus.en && bus.stream_valid && (state_q == ES_RUN);
    assign terminal = accept && (win_cnt_q == {WXI{1'b1}});

    always_comb begin
        state_d   = state_q;
        win_cnt_d = win_cnt_q;
        result_d  = result_q;
        clr       = 1'b0;
        unique case (state_q)
            ES_IDLE, ES_DONE: begin
                if (bus.en && bus.start) begin
                    state_d   = ES_RUN;
                    win_cnt_d = '0;
                    clr       = 1'b1;
                end
            end
            ES_RUN: begin
                // start is ignored here; only the terminal bit leaves RUN
                if (accept) begin
                    win_cnt_d = win_cnt_q + WXI'(1);
                end
                if (terminal) begin
                    state_d  = ES_DONE;
                    result_d = ones_cnt + WXIP1'(bus.stream_in);
                end
            end
            default: state_d = ES_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ES_IDLE;
            win_cnt_q <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            win_cnt_q <= win_cnt_d;
            result_q  <= result_d;
        end
    end

    es_ones_counter #(
        .W(WXIP1)
    ) u_ones (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (clr),
        .inc_en_i (accept),
        .bit_i    (bus.stream_in),
        .cnt_o    (ones_cnt)
    );

    assign bus.busy         = (state_q == ES_RUN);
    assign bus.done         = (state_q == ES_DONE);
    assign bus.bin_data_out = result_q;
    assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_es_stream_to_bin.sv
// Bench for es_stream_to_bin: random windows against a counting model, scoreboard on done.
module tb_es_stream_to_bin;
    import es_pkg::*;

    localparam int WIN   = 1024;
    localparam int WXIP1 = 11;

    logic clk;
    logic rst;
    int   cyc;
    int   start_cyc;
    int   n_checks;
    int   n_pass;

    logic [WXIP1-1:0] exp_q[$];
    logic             win_bits [WIN];

    es_stream_to_bin_if #(.WXIP1(WXIP1)) bus ();

    es_stream_to_bin #(
        .DATA_WIDTH (5),
        .NUM_INPUTS (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // reference model: a window's result is simply the number of 1s among its accepted bits
    task automatic gen_window(input int mode, input bit push);
        int sum;
        sum = 0;
        for (int k = 0; k < WIN; k++) begin
            case (mode)
                0:       win_bits[k] = 1'b1;
                1:       win_bits[k] = 1'b0;
                2:       win_bits[k] = (k % 2 == 0);
                3:       win_bits[k] = (k % 32 == 0);
                default: win_bits[k] = 1'($urandom_range(0, 1));
            endcase
            sum += int'(win_bits[k]);
        end
        if (push) exp_q.push_back(WXIP1'(sum));
    endtask

    // driver tasks
    task automatic do_start();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        bus.start = 1'b0;
    endtask

    task automatic drive_window(input int duty, input int freeze_at, input int rst_at,
                                input int start_at, input int hold_exp);
        int k;
        bit early;
        bit froze;
        bit v;
        k = 0;
        early = 1'b0;
        froze = 1'b0;
        while (k < WIN) begin
            if (k == rst_at) begin
                bus.stream_valid = 1'b1;
                bus.stream_in    = 1'b1;
                rst       = 1'b1;
                bus.start = 1'b1;
                @(posedge clk);
                #1;
                rst       = 1'b0;
                bus.start = 1'b0;
                bus.stream_valid = 1'b0;
                check("rst_state", int'(bus.dbg_state), int'(ES_IDLE));
                check("rst_result", int'(bus.bin_data_out), 0);
                check("rst_done", int'(bus.done), 0);
                check("rst_busy", int'(bus.busy), 0);
                return;
            end
            if (k == freeze_at && !froze) begin
                bus.en           = 1'b0;
                bus.stream_valid = 1'b1;
                bus.stream_in    = 1'b1;
                repeat (20) @(posedge clk);
                #1;
                check("freeze_busy", int'(bus.busy), 1);
                bus.en = 1'b1;
                froze  = 1'b1;
            end
            if (k == WIN - 1 && hold_exp >= 0) begin
                check("hold_result", int'(bus.bin_data_out), hold_exp);
            end
            v = (duty >= 100) ? 1'b1 : ($urandom_range(0, 99) < duty);
            bus.stream_valid = v;
            bus.stream_in    = win_bits[k];
            bus.start        = v && (k == start_at);
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            if (v) k++;
            if (k < WIN && bus.done) early = 1'b1;
        end
        bus.stream_valid = 1'b0;
        bus.stream_in    = 1'b0;
        check("early_done", int'(early), 0);
    endtask

    task automatic wait_done(input bit chk_lat);
        int n;
        n = 0;
        while (!bus.done && n < 8) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("done_seen", int'(bus.done), 1);
        if (chk_lat) check("latency", cyc - start_cyc + 1, WIN + 1);
    endtask

    // scoreboard monitor: pops one expected result per rising done
    initial begin
        bit done_prev;
        logic [WXIP1-1:0] exp;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.done && !done_prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp = exp_q.pop_front();
                    check("result", int'(bus.bin_data_out), int'(exp));
                end
            end
            done_prev = bus.done;
        end
    end

    // main sequence
    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        bus.en           = 1'b1;
        bus.start        = 1'b0;
        bus.stream_in    = 1'b0;
        bus.stream_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_state", int'(bus.dbg_state), int'(ES_IDLE));
        check("reset_result", int'(bus.bin_data_out), 0);
        check("reset_done", int'(bus.done), 0);
        check("reset_busy", int'(bus.busy), 0);

        // all ones, valid tied high: 1024 with fixed latency
        gen_window(0, 1'b1);
        do_start();
        drive_window(100, -1, -1, -1, -1);
        wait_done(1'b1);

        // back-to-back from DONE into an all-zeros window, with a stray mid-run start
        gen_window(1, 1'b1);
        do_start();
        check("b2b_done_low", int'(bus.done), 0);
        check("b2b_hold", int'(bus.bin_data_out), WIN);
        drive_window(100, -1, -1, 500, WIN);
        wait_done(1'b1);

        // alternating and first-1-per-32 patterns
        gen_window(2, 1'b1);
        do_start();
        drive_window(100, -1, -1, -1, -1);
        wait_done(1'b1);
        gen_window(3, 1'b1);
        do_start();
        drive_window(100, -1, -1, -1, -1);
        wait_done(1'b1);

        // random data, random valid gaps, en freeze mid-run
        gen_window(4, 1'b1);
        do_start();
        drive_window(50, 300, -1, -1, -1);
        wait_done(1'b0);

        // all ones with random valid gaps
        gen_window(0, 1'b1);
        do_start();
        drive_window(50, -1, -1, -1, -1);
        wait_done(1'b0);

        // reset mid-window (with start held during reset), then a clean window
        gen_window(4, 1'b0);
        do_start();
        drive_window(100, -1, 600, -1, -1);
        gen_window(4, 1'b1);
        do_start();
        drive_window(100, -1, -1, WIN - 1, 0);
        wait_done(1'b1);
        @(posedge clk);
        #1;
        check("start_on_terminal_done", int'(bus.done), 1);

        repeat (3) @(posedge clk);
        #1;
        check("exp_q_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
